// File: rtl/wb_search_port_pkg.sv
// wb_search_defs: shared definitions for wb_search_port.
// Holds register offsets, CTRL/STATUS bit positions, default sizing,
// the "no match yet" FIRST_IDX value and small helper functions.
package wb_search_defs;

  localparam logic [31:0] BASE_ADDR_DEF  = 32'h3000_0000;
  localparam int          FIFO_DEPTH_DEF = 8;

  // Register offsets within the 256-byte window
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_KEY    = 8'h04;
  localparam logic [7:0] OFF_MASK   = 8'h08;
  localparam logic [7:0] OFF_DATA   = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;
  localparam logic [7:0] OFF_COUNT  = 8'h14;
  localparam logic [7:0] OFF_FIRST  = 8'h18;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bit positions (level occupies [4:0])
  localparam int STATUS_FULL  = 5;
  localparam int STATUS_EMPTY = 6;
  localparam int STATUS_FOUND = 7;
  localparam int STATUS_BUSY  = 8;

  localparam logic [15:0] FIRST_IDX_NONE = 16'hFFFF;

  // Increment that sticks at the all-ones value
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Replace only the byte lanes selected by sel
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        r[i*8 +: 8] = new_v[i*8 +: 8];
      end else begin
        r[i*8 +: 8] = old_v[i*8 +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_search_port_sync_fifo.sv
// sync_fifo: single-clock FIFO with flush.
// Ports: clk, rst_n (sync, active-low), flush (clears contents, beats push),
//        push/din, pop/dout (head word, valid when !empty), level, full, empty.
// A push while full and a pop while empty are ignored.
module sync_fifo
  import wb_search_defs::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (level_r == LW'(DEPTH));
  assign empty     = (level_r == '0);
  assign level     = level_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Storage array; written only on an accepted, non-flushed push
  always_ff @(posedge clk) begin
    if (do_push_s && !flush && rst_n) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_r + LW'(do_push_s) - LW'(do_pop_s);
    end
  end

endmodule

// File: rtl/wb_search_port.sv
// wb_search_port: Wishbone-classic slave that streams words through a FIFO
// into a pop/compare pipeline counting masked key matches.
// Ports: wb_clk_i, wb_rst_n (sync, active-low), wbs_cyc_i/stb_i/we_i/sel_i/
//        adr_i/dat_i (request), wbs_ack_o (one-cycle ack), wbs_dat_o (read
//        data, 0 when not acking), irq_o (IRQ_EN & found, level).
module wb_search_port
  import wb_search_defs::*;
#(
  parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          ack_r, en_r, irq_en_r, found_r;
  logic [31:0]   dat_r, key_r, mask_r;
  logic          cmp_valid_r, cmp_hit_r;
  logic [15:0]   cmp_idx_r, idx_r, count_r, first_r;

  logic [7:0]    off_s;
  logic          req_s, in_win_s, stall_s, accept_s, wr_s;
  logic          clr_s, push_s, pop_s, hit_s;
  logic [31:0]   head_s, rdata_s, status_s;
  logic [LW-1:0] level_s;
  logic          full_s, empty_s;

  assign off_s    = wbs_adr_i[7:0];
  assign req_s    = wbs_cyc_i & wbs_stb_i & ~ack_r;
  assign in_win_s = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // A DATA write into a full FIFO is held off (no ack) until space appears
  assign stall_s  = wbs_we_i & (off_s == OFF_DATA) & full_s;
  assign accept_s = req_s & in_win_s & ~stall_s;
  assign wr_s     = accept_s & wbs_we_i;
  assign clr_s    = wr_s & (off_s == OFF_CTRL) & wbs_sel_i[0] & wbs_dat_i[CTRL_CLR];
  assign push_s   = wr_s & (off_s == OFF_DATA);
  assign pop_s    = en_r & ~empty_s;
  assign hit_s    = (((head_s ^ key_r) & mask_r) == 32'd0);

  assign wbs_ack_o = ack_r;
  assign wbs_dat_o = dat_r;
  assign irq_o     = irq_en_r & found_r;

  sync_fifo #(.W(32), .DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n),
    .flush (clr_s),
    .push  (push_s),
    .din   (wbs_dat_i),
    .pop   (pop_s),
    .dout  (head_s),
    .level (level_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // STATUS word assembly
  always_comb begin
    status_s               = 32'd0;
    status_s[LW-1:0]       = level_s;
    status_s[STATUS_FULL]  = full_s;
    status_s[STATUS_EMPTY] = empty_s;
    status_s[STATUS_FOUND] = found_r;
    status_s[STATUS_BUSY]  = cmp_valid_r;
  end

  // Read mux; DATA and unmapped offsets read as zero
  always_comb begin
    rdata_s = 32'd0;
    case (off_s)
      OFF_CTRL:   rdata_s = {29'd0, irq_en_r, 1'b0, en_r};
      OFF_KEY:    rdata_s = key_r;
      OFF_MASK:   rdata_s = mask_r;
      OFF_STATUS: rdata_s = status_s;
      OFF_COUNT:  rdata_s = {16'd0, count_r};
      OFF_FIRST:  rdata_s = {16'd0, first_r};
      default:    rdata_s = 32'd0;
    endcase
  end

  // Bus response and writable registers
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      ack_r    <= 1'b0;
      dat_r    <= 32'd0;
      en_r     <= 1'b0;
      irq_en_r <= 1'b0;
      key_r    <= 32'd0;
      mask_r   <= 32'd0;
    end else begin
      ack_r <= accept_s;
      dat_r <= (accept_s && !wbs_we_i) ? rdata_s : 32'd0;
      if (wr_s && (off_s == OFF_CTRL) && wbs_sel_i[0]) begin
        en_r     <= wbs_dat_i[CTRL_EN];
        irq_en_r <= wbs_dat_i[CTRL_IRQ_EN];
      end
      if (wr_s && (off_s == OFF_KEY)) begin
        key_r <= byte_merge(key_r, wbs_dat_i, wbs_sel_i);
      end
      if (wr_s && (off_s == OFF_MASK)) begin
        mask_r <= byte_merge(mask_r, wbs_dat_i, wbs_sel_i);
      end
    end
  end

  // Pop/compare pipeline: stage 1 latches hit+index at pop, stage 2 retires
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      cmp_valid_r <= 1'b0;
      cmp_hit_r   <= 1'b0;
      cmp_idx_r   <= 16'd0;
      idx_r       <= 16'd0;
      count_r     <= 16'd0;
      first_r     <= FIRST_IDX_NONE;
      found_r     <= 1'b0;
    end else if (clr_s) begin
      // CLR beats a same-edge pop or retire
      cmp_valid_r <= 1'b0;
      cmp_hit_r   <= 1'b0;
      cmp_idx_r   <= 16'd0;
      idx_r       <= 16'd0;
      count_r     <= 16'd0;
      first_r     <= FIRST_IDX_NONE;
      found_r     <= 1'b0;
    end else begin
      cmp_valid_r <= pop_s;
      if (pop_s) begin
        cmp_hit_r <= hit_s;
        cmp_idx_r <= idx_r;
        idx_r     <= sat_inc16(idx_r);
      end
      if (cmp_valid_r && cmp_hit_r) begin
        count_r <= sat_inc16(count_r);
        if (!found_r) begin
          first_r <= cmp_idx_r;
          found_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_search_port.sv
// Scoreboard bench for wb_search_port: each bus transfer queues the expected
// read data (0 for writes); a negedge monitor pops and compares on every ack.
module tb_wb_search_port;

  localparam logic [31:0] A_CTRL   = 32'h3000_0000;
  localparam logic [31:0] A_KEY    = 32'h3000_0004;
  localparam logic [31:0] A_MASK   = 32'h3000_0008;
  localparam logic [31:0] A_DATA   = 32'h3000_000C;
  localparam logic [31:0] A_STATUS = 32'h3000_0010;
  localparam logic [31:0] A_COUNT  = 32'h3000_0014;
  localparam logic [31:0] A_FIRST  = 32'h3000_0018;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'd0, wdat = 32'd0;
  logic        ack, irq;
  logic [31:0] rdat;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  wb_search_port dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .irq_o    (irq)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
    end
  endtask

  // Monitor: every ack must match the head of the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {31'd0, ack}, 32'd0);
        end else begin
          automatic string nm = name_q.pop_front();
          automatic logic [31:0] e = exp_q.pop_front();
          check(nm, rdat, e);
        end
      end else begin
        check("dat_idle_zero", rdat, 32'd0);
      end
    end
  end

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] expv, input string nm);
    int n;
    exp_q.push_back(w ? 32'd0 : expv);
    name_q.push_back(nm);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ack !== 1'b1 && n < 40);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (ack !== 1'b1) begin
      check({nm, "_timeout"}, {31'd0, ack}, 32'd1);
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    xfer(1'b1, a, d, 4'hF, 32'd0, "write_ack");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] expv, input string nm);
    xfer(1'b0, a, 32'd0, 4'hF, expv, nm);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    cycles(3);
    rst_n = 1'b1;
    mon_en = 1'b1;
    cycles(1);

    // Reset values
    check("irq_reset", {31'd0, irq}, 32'd0);
    rd(A_CTRL,   32'd0,          "ctrl_reset");
    rd(A_KEY,    32'd0,          "key_reset");
    rd(A_MASK,   32'd0,          "mask_reset");
    rd(A_DATA,   32'd0,          "data_reads_zero");
    rd(A_STATUS, 32'h0000_0040,  "status_reset");
    rd(A_COUNT,  32'd0,          "count_reset");
    rd(A_FIRST,  32'h0000_FFFF,  "first_reset");

    // Basic search with interrupt timing
    wr(A_KEY,  32'hAB60_0000);
    wr(A_MASK, 32'hFFFF_0000);
    wr(A_CTRL, 32'h0000_0005);
    wr(A_DATA, 32'h1234_0000);
    wr(A_DATA, 32'hAB60_1111);
    cycles(1);
    check("irq_e_plus_1", {31'd0, irq}, 32'd0);
    cycles(1);
    check("irq_e_plus_2", {31'd0, irq}, 32'd1);
    wr(A_DATA, 32'hAB60_2222);
    cycles(4);
    rd(A_COUNT,  32'd2,         "count_two");
    rd(A_FIRST,  32'd1,         "first_one");
    rd(A_STATUS, 32'h0000_00C0, "status_found");

    // Full FIFO stall with EN=0, released by forcing EN
    wr(A_CTRL, 32'h0000_0006);
    for (int i = 0; i < 8; i++) begin
      wr(A_DATA, 32'hAB60_0000 + 32'(i));
    end
    rd(A_STATUS, 32'h0000_0028, "status_full");
    fork
      wr(A_DATA, 32'hAB60_0008);
      begin
        for (int i = 0; i < 6; i++) begin
          @(posedge clk); #1;
          check("stall_no_ack", {31'd0, ack}, 32'd0);
        end
        force dut.en_r = 1'b1;
      end
    join
    cycles(20);
    wr(A_CTRL, 32'h0000_0005);
    release dut.en_r;
    rd(A_COUNT,  32'd9,         "count_nine");
    rd(A_FIRST,  32'd0,         "first_zero");
    rd(A_STATUS, 32'h0000_00C0, "status_drained");

    // CLR on the same edge as a retire
    wr(A_DATA, 32'hAB60_0009);
    wr(A_CTRL, 32'h0000_0007);
    check("irq_after_clr", {31'd0, irq}, 32'd0);
    rd(A_COUNT,  32'd0,         "count_clr");
    rd(A_FIRST,  32'h0000_FFFF, "first_clr");
    rd(A_STATUS, 32'h0000_0040, "status_clr");
    rd(A_CTRL,   32'h0000_0005, "ctrl_clr_reads_0");

    // Unmapped in-window offsets
    rd(32'h3000_001C, 32'd0, "unmapped_read");
    wr(32'h3000_00F0, 32'hDEAD_BEEF);

    // Out-of-window: never acked
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0100; sel = 4'hF;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      check("oow_no_ack", {31'd0, ack}, 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;
    cycles(1);

    // Byte-lane write to KEY
    wr(A_KEY, 32'h1111_1111);
    xfer(1'b1, A_KEY, 32'h0000_CD00, 4'b0010, 32'd0, "write_ack");
    rd(A_KEY, 32'h1111_CD11, "key_byte_merge");

    // Reset mid-stream with words queued and a request outstanding
    wr(A_DATA, 32'h1111_0000);
    cycles(3);
    check("irq_before_reset", {31'd0, irq}, 32'd1);
    wr(A_CTRL, 32'h0000_0004);
    for (int i = 0; i < 4; i++) begin
      wr(A_DATA, 32'h0000_0100 + 32'(i));
    end
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STATUS; sel = 4'hF;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_no_ack", {31'd0, ack}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check("rst_no_ack2", {31'd0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    rst_n = 1'b1;
    cycles(1);
    rd(A_CTRL,   32'd0,         "ctrl_after_rst");
    rd(A_KEY,    32'd0,         "key_after_rst");
    rd(A_MASK,   32'd0,         "mask_after_rst");
    rd(A_STATUS, 32'h0000_0040, "status_after_rst");
    rd(A_COUNT,  32'd0,         "count_after_rst");
    rd(A_FIRST,  32'h0000_FFFF, "first_after_rst");

    cycles(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
